multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised second-generation control unit for the multi-cycle accumulator CPU. It sequences fetch, decode, operand load, ALU execute, write-back, store and conditional branch. New over the first generation: multiple accumulators, a memory ready handshake with wait states, illegal-opcode trapping and an optional memory timeout. It drives the datapath enables and the memory strobes.

## Interface
- ACC_SEL_W, 2, accumulator select width; 2^ACC_SEL_W accumulators
- TIMEOUT, 15, maximum wait cycles on mem_ready before trapping (only used with CTRL_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; pulse high then low to begin
- op  in  4  opcode field from IR, valid from the cycle after IR load
- acc_field  in  ACC_SEL_W  accumulator field from IR
- czn  in  3  flags {C,Z,N}
- mem_ready  in  1  memory completes current read/write this cycle
- done, busy, err  out  1  idle / executing / trapped
- pc_inc, pc_ld, addr_sel  out  1  PC +1 / PC<-TR / memory address (0=PC, 1=TR)
- mem_rd, mem_wr  out  1  memory strobes
- ir_ld, tr_ld, di_ld, a_ld, b_ld, a_zero  out  1  register loads; a_zero forces ALU A input to 0
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT A
- alu_res_ld, ld_czn, acc_we  out  1  ALU result load / flag load / accumulator write
- acc_sel  out  ACC_SEL_W  registered accumulator select

## Operation
- Opcodes:
  - 0000 LDA
  - 0001 STA
  - 0010 ADD
  - 0011 SUB
  - 0100 AND
  - 0101 NOT
  - 0110 JMP
  - 0111 JZ
  - 1000 JC
  - 1001 JN
  - 1111 HLT
  - all others are illegal.
- Two-word opcodes: 0000–0100 and 0110–1001. The second word is the address, loaded into TR.
- IDLE: done=1. start=1 -> START.
- START: start=0 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0. On mem_ready: ir_ld=1, pc_inc=1, -> DECODE.
- DECODE: latch acc_sel<=acc_field. Next state by op:
  - two-word -> FETCH2
  - NOT -> OPLD
  - HLT -> IDLE
  - illegal -> ERR
- FETCH2: mem_rd=1, addr_sel=0. On mem_ready: tr_ld=1, pc_inc=1. Next state:
  - LDA/ADD/SUB/AND -> LDDATA
  - STA -> STORE
  - jumps -> BRANCH
- LDDATA: mem_rd=1, addr_sel=1. On mem_ready: di_ld=1, -> OPLD.
- OPLD: a_ld=1, b_ld=1; a_zero=1 for LDA. -> EXEC.
- EXEC: alu_res_ld=1, ld_czn=1. alu_op: ADD/LDA 00, SUB 01, AND 10, NOT 11. -> WRACC.
- WRACC: acc_we=1, -> FETCH.
- STORE: mem_wr=1, addr_sel=1. On mem_ready -> FETCH.
- BRANCH: pc_ld=1 if JMP, or if the selected flag is set (JZ: czn[1], JC: czn[2], JN: czn[0]). -> FETCH.
- ERR: err=1, all other outputs 0. start=1 -> START.
- busy=1 in every state except IDLE, START and ERR.
- Memory states hold all strobes and state while mem_ready=0. Load strobes assert only in the mem_ready=1 cycle.

## Timing
- Outputs are combinational from state. Load strobes in memory states are additionally gated by mem_ready.
- Cycle counts with mem_ready tied to 1, FETCH to next FETCH:
  - LDA/ADD/SUB/AND: 7
  - NOT: 5
  - STA: 4
  - jumps: 4
  - HLT: FETCH + DECODE, then IDLE
- Each wait cycle adds 1.
- Reset (rst=0, any state, any time):
  - state -> IDLE immediately; acc_sel=0; wait counter=0
  - all outputs 0 except done=1
- Reset released mid-instruction: the controller waits for a fresh start pulse.
- start held high in IDLE: stays in START until it falls.
- start during execution: ignored.
- Flags are sampled in BRANCH. Flags written by the preceding EXEC are visible there.

## Configuration
- CTRL_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) counts consecutive mem_ready=0 cycles in FETCH, FETCH2, LDDATA and STORE.
  - The counter clears on state exit.
  - When the count reaches TIMEOUT with mem_ready still 0 -> ERR next cycle.
- CTRL_TIMEOUT_EN undefined:
  - No counter; memory states wait indefinitely.
  - ERR is reached only by an illegal opcode.

## Test plan
- Reset, start pulse, mem_ready=1, program LDA 0x10 (mem=0x05), ADD 0x11 (mem=0x03), STA 0x12, HLT -> the following, then done=1:
  - alu_op 00 with a_zero=1, then 00 with a_zero=0
  - mem_wr at addr_sel=1
  - 7+7+4+2 cycles
- JZ with czn=3'b010 -> pc_ld=1 in BRANCH. Same with czn=3'b000 -> pc_ld=0, and the next FETCH follows.
- Opcode 1010 -> DECODE then ERR with err=1, busy=0. A start pulse then returns to FETCH.
- mem_ready low for 3 cycles in LDDATA -> di_ld asserts exactly once, in the 4th cycle; state held.
- With CTRL_TIMEOUT_EN and TIMEOUT=15, mem_ready held 0 in FETCH -> ERR after 15 wait cycles. Without the macro, FETCH is held indefinitely.
- rst low asserted mid-EXEC with acc_field=2'b11 -> outputs zero, done=1, acc_sel=0 without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle accumulator CPU control unit: fetch/decode/operand/execute/store/branch sequencing.
// Optional memory wait timeout is enabled by defining CTRL_TIMEOUT_EN.
module multicycle_controller #(
  parameter int ACC_SEL_W = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [ACC_SEL_W-1:0] acc_field,
  input  logic [2:0]           czn,
  input  logic                 mem_ready,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic                 pc_inc,
  output logic                 pc_ld,
  output logic                 addr_sel,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 ir_ld,
  output logic                 tr_ld,
  output logic                 di_ld,
  output logic                 a_ld,
  output logic                 b_ld,
  output logic                 a_zero,
  output logic [1:0]           alu_op,
  output logic                 alu_res_ld,
  output logic                 ld_czn,
  output logic                 acc_we,
  output logic [ACC_SEL_W-1:0] acc_sel,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_FETCH2 = 4'd4,
    S_LDDATA = 4'd5,
    S_OPLD   = 4'd6,
    S_EXEC   = 4'd7,
    S_WRACC  = 4'd8,
    S_STORE  = 4'd9,
    S_BRANCH = 4'd10,
    S_ERR    = 4'd11
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_JC  = 4'b1000;
  localparam logic [3:0] OP_JN  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t                 state_q, state_d;
  logic [ACC_SEL_W-1:0]   acc_sel_q, acc_sel_d;
  logic                   timeout;

  // Two-word opcodes carry an address word that is loaded into TR.
  function automatic logic is_two_word(input logic [3:0] o);
    return (o <= OP_AND) || ((o >= OP_JMP) && (o <= OP_JN));
  endfunction

`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_state;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_FETCH2) ||
                     (state_q == S_LDDATA) || (state_q == S_STORE);
  // Trap on the wait cycle that brings the consecutive count up to TIMEOUT.
  assign timeout   = mem_state && !mem_ready && (wait_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wait_d = '0;
    if (mem_state && !mem_ready && !timeout) wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  // No timeout in this build; the expression is constant false for any legal TIMEOUT.
  assign timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_sel_q <= acc_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_sel_d  = acc_sel_q;
    done       = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_ld      = 1'b0;
    tr_ld      = 1'b0;
    di_ld      = 1'b0;
    a_ld       = 1'b0;
    b_ld       = 1'b0;
    a_zero     = 1'b0;
    alu_op     = 2'b00;
    alu_res_ld = 1'b0;
    ld_czn     = 1'b0;
    acc_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        done = 1'b1;
        if (start) state_d = S_START;
      end
      S_START: begin
        if (!start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (timeout) state_d = S_ERR;
        else if (mem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        busy      = 1'b1;
        acc_sel_d = acc_field;
        if (is_two_word(op))  state_d = S_FETCH2;
        else if (op == OP_NOT) state_d = S_OPLD;
        else if (op == OP_HLT) state_d = S_IDLE;
        else                   state_d = S_ERR;
      end
      S_FETCH2: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (timeout) state_d = S_ERR;
        else if (mem_ready) begin
          tr_ld  = 1'b1;
          pc_inc = 1'b1;
          if (op == OP_STA)                        state_d = S_STORE;
          else if ((op >= OP_JMP) && (op <= OP_JN)) state_d = S_BRANCH;
          else                                     state_d = S_LDDATA;
        end
      end
      S_LDDATA: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (timeout) state_d = S_ERR;
        else if (mem_ready) begin
          di_ld   = 1'b1;
          state_d = S_OPLD;
        end
      end
      S_OPLD: begin
        busy    = 1'b1;
        a_ld    = 1'b1;
        b_ld    = 1'b1;
        a_zero  = (op == OP_LDA);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy       = 1'b1;
        alu_res_ld = 1'b1;
        ld_czn     = 1'b1;
        case (op)
          OP_SUB:  alu_op = 2'b01;
          OP_AND:  alu_op = 2'b10;
          OP_NOT:  alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
        state_d = S_WRACC;
      end
      S_WRACC: begin
        busy    = 1'b1;
        acc_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_STORE: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (timeout)        state_d = S_ERR;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        busy = 1'b1;
        // czn is {C,Z,N}
        case (op)
          OP_JMP:  pc_ld = 1'b1;
          OP_JZ:   pc_ld = czn[1];
          OP_JC:   pc_ld = czn[2];
          OP_JN:   pc_ld = czn[0];
          default: pc_ld = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) acc_sel_d = '0;
  end

  assign acc_sel   = acc_sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: program run, branches, wait states, traps and reset.
module tb_multicycle_controller;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_FETCH  = 4'd2;
  localparam logic [3:0] S_LDDATA = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd11;

  logic       clk, rst, start, mem_ready;
  logic [3:0] op;
  logic [1:0] acc_field;
  logic [2:0] czn;
  logic       done, busy, err, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr;
  logic       ir_ld, tr_ld, di_ld, a_ld, b_ld, a_zero, alu_res_ld, ld_czn, acc_we;
  logic [1:0] alu_op;
  logic [1:0] acc_sel;
  logic [3:0] dbg_state;

  multicycle_controller #(.ACC_SEL_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc_field(acc_field),
    .czn(czn), .mem_ready(mem_ready), .done(done), .busy(busy), .err(err),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .addr_sel(addr_sel), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .ir_ld(ir_ld), .tr_ld(tr_ld), .di_ld(di_ld), .a_ld(a_ld),
    .b_ld(b_ld), .a_zero(a_zero), .alu_op(alu_op), .alu_res_ld(alu_res_ld),
    .ld_czn(ld_czn), .acc_we(acc_we), .acc_sel(acc_sel), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_q[$];
  int         alu_extra = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [17:0] outs_vec();
    return {busy, err, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr, ir_ld, tr_ld,
            di_ld, a_ld, b_ld, a_zero, alu_op, alu_res_ld, ld_czn, acc_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Runs one instruction starting in FETCH until the next FETCH, IDLE or ERR.
  task automatic run_instr(input logic [3:0] opc, input logic [1:0] acc,
                           input logic [2:0] flags, input int ld_waits,
                           output int cyc, output logic azero, output logic [1:0] wr_info,
                           output logic pcld, output int di_cnt, output int di_at,
                           output int wait_ok);
    int waits_left;
    int ld_cyc;
    waits_left = ld_waits;
    ld_cyc = 0;
    cyc = 0; azero = 1'b0; wr_info = 2'b00; pcld = 1'b0;
    di_cnt = 0; di_at = 0; wait_ok = 0;
    op = opc; acc_field = acc; czn = flags;
    do begin
      mem_ready = !((dbg_state == S_LDDATA) && (waits_left > 0));
      #1;
      cyc++;
      if (a_ld) azero = a_zero;
      if (mem_wr) wr_info = {1'b1, addr_sel};
      if (pc_ld) pcld = 1'b1;
      if (dbg_state == S_LDDATA) begin
        ld_cyc++;
        if (!mem_ready) begin
          waits_left--;
          if (mem_rd && addr_sel && !di_ld) wait_ok++;
        end
      end
      if (di_ld) begin
        di_cnt++;
        di_at = ld_cyc;
      end
      if (alu_res_ld) begin
        if (exp_q.size() > 0) check("alu_op", {30'd0, alu_op}, {30'd0, exp_q.pop_front()});
        else alu_extra++;
      end
      @(posedge clk);
      #1;
    end while (!(dbg_state inside {S_FETCH, S_IDLE, S_ERR}) && cyc < 50);
    mem_ready = 1'b1;
  endtask

  int         cyc, di_cnt, di_at, wait_ok, cnt;
  logic       azero, pcld;
  logic [1:0] wr_info;

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; acc_field = 2'd0; czn = 3'd0; mem_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_done", done, 1);
    check("rst_outs", outs_vec(), 0);
    check("rst_acc_sel", acc_sel, 0);
    #20;
    @(negedge clk) rst = 1'b1;
    tick(); tick();
    check("idle_no_start", dbg_state, S_IDLE);

    // start held high stays in START until it falls
    start = 1'b1;
    tick(); tick(); tick();
    check("start_held", dbg_state, S_START);
    check("start_not_busy", {done, busy}, 2'b00);
    start = 1'b0;
    tick();
    check("start_to_fetch", dbg_state, S_FETCH);

    // Program: LDA 0x10, ADD 0x11, STA 0x12, HLT
    exp_q.push_back(2'b00);
    run_instr(4'b0000, 2'd1, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("lda_cycles", cyc, 7);
    check("lda_a_zero", azero, 1);
    check("lda_di_ld", di_cnt, 1);
    exp_q.push_back(2'b00);
    run_instr(4'b0010, 2'd1, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("add_cycles", cyc, 7);
    check("add_a_zero", azero, 0);
    run_instr(4'b0001, 2'd1, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("sta_cycles", cyc, 4);
    check("sta_wr_addr_sel", wr_info, 2'b11);
    run_instr(4'b1111, 2'd2, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("hlt_cycles", cyc, 2);
    check("hlt_done", done, 1);
    check("hlt_acc_sel", acc_sel, 2);

    start_pulse();
    check("restart_fetch", dbg_state, S_FETCH);

    // Branches
    run_instr(4'b0111, 2'd0, 3'b010, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("jz_taken_cycles", cyc, 4);
    check("jz_taken_pc_ld", pcld, 1);
    run_instr(4'b0111, 2'd0, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("jz_not_taken_pc_ld", pcld, 0);
    check("jz_next_fetch", dbg_state, S_FETCH);
    run_instr(4'b1000, 2'd0, 3'b010, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("jc_wrong_flag_pc_ld", pcld, 0);
    run_instr(4'b1001, 2'd0, 3'b001, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("jn_taken_pc_ld", pcld, 1);
    run_instr(4'b0110, 2'd0, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("jmp_pc_ld", pcld, 1);

    // ALU ops
    exp_q.push_back(2'b11);
    run_instr(4'b0101, 2'd3, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("not_cycles", cyc, 5);
    exp_q.push_back(2'b01);
    run_instr(4'b0011, 2'd0, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("sub_cycles", cyc, 7);
    exp_q.push_back(2'b10);
    run_instr(4'b0100, 2'd0, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("and_cycles", cyc, 7);

    // Wait states in LDDATA
    exp_q.push_back(2'b00);
    run_instr(4'b0000, 2'd0, 3'b000, 3, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("wait_cycles", cyc, 10);
    check("wait_di_once", di_cnt, 1);
    check("wait_di_4th", di_at, 4);
    check("wait_held", wait_ok, 3);

    // Illegal opcode traps
    run_instr(4'b1010, 2'd1, 3'b000, 0, cyc, azero, wr_info, pcld, di_cnt, di_at, wait_ok);
    check("illegal_cycles", cyc, 2);
    check("illegal_state", dbg_state, S_ERR);
    check("illegal_err_busy_done", {err, busy, done}, 3'b100);
    start_pulse();
    check("err_restart_fetch", dbg_state, S_FETCH);

    // Memory never ready in FETCH
    mem_ready = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    cnt = 0;
    while (dbg_state == S_FETCH && cnt < 100) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, 15);
    check("timeout_err", err, 1);
    mem_ready = 1'b1;
    start_pulse();
    check("timeout_restart", dbg_state, S_FETCH);
`else
    repeat (40) tick();
    check("no_timeout_state", dbg_state, S_FETCH);
    check("no_timeout_strobe", {mem_rd, err, ir_ld}, 3'b100);
    mem_ready = 1'b1;
`endif

    // Asynchronous reset mid-EXEC
    op = 4'b0101; acc_field = 2'b11; mem_ready = 1'b1;
    for (int i = 0; i < 10 && dbg_state != S_EXEC; i++) tick();
    check("exec_reached", dbg_state, S_EXEC);
    check("exec_acc_sel", acc_sel, 3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", dbg_state, S_IDLE);
    check("async_rst_done", done, 1);
    check("async_rst_outs", outs_vec(), 0);
    check("async_rst_acc_sel", acc_sel, 0);
    @(negedge clk) rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle", dbg_state, S_IDLE);

    check("alu_q_empty", exp_q.size(), 0);
    check("alu_extra", alu_extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
